// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and default frame constants.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int OS_DEF        = 16;
  localparam int DATA_BITS_DEF = 8;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } rx_state_t;
`endif

  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk down to the oversample tick.
// A synchronous clear realigns the tick phase to a start edge.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with majority vote.
// Define UART_PARITY_EN to expect a parity bit before the stop bit.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int OS         = OS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 wr_EN,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int OSW = $clog2(OS);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [OSW-1:0] OS_MID  = OSW'(OS / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OS - 1);
  localparam logic [BW-1:0]  B_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 sync1;
  logic                 sync2;
  logic                 rx_d;
  logic                 tick;
  logic                 start_edge;
  logic                 centre;
  logic                 vote;
  logic [2:0]           hist;
  logic [2:0]           hist_nxt;
  logic [OSW-1:0]       os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

`ifdef UART_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  // Vote over the history including the sample taken on this tick.
  assign hist_nxt   = {hist[1:0], sync2};
  assign vote       = maj3(hist_nxt);
  assign start_edge = (state == IDLE) && rx_d && !sync2;
  assign centre     = tick && (os_cnt == OS_LAST);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_edge),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      rx_d      <= 1'b1;
      hist      <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dataout   <= '0;
      wr_EN     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      rx_d      <= sync2;
      wr_EN     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) begin
        hist   <= hist_nxt;
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= START;
            os_cnt <= '0;
            hist   <= 3'b000;
            busy   <= 1'b1;
          end
        end
        START: begin
          if (tick && os_cnt == OS_MID) begin
            if (!vote) begin
              state   <= DATA;
              os_cnt  <= '0;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (centre) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_cnt == B_LAST) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (centre) begin
            par_bad <= vote != ((^shreg) ^ ODD);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (centre) begin
`ifdef UART_PARITY_EN
            wr_EN      <= vote && !par_bad;
            parity_err <= par_bad;
            if (vote && !par_bad) dataout <= shreg;
`else
            wr_EN <= vote;
            if (vote) dataout <= shreg;
`endif
            frame_err <= !vote;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: serial frames driven at T=64 clk, strobes
// collected by a monitor and compared with expected frame outcomes.
module tb_uart_rx_os;

  localparam int DIV  = 4;
  localparam int OS   = 16;
  localparam int DB   = 8;
  localparam int PODD = 0;
  localparam int T    = DIV * OS;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // (1 + DB + P + 0.5) * T + 3 clk
  localparam int LAT = ((3 + 2 * DB + 2 * P) * T) / 2 + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] dataout;
  logic          wr_EN;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int wide_cnt = 0;
  logic [7:0] got_d[$];
  int         got_c[$];
  logic [7:0] last_good = 8'h00;
  logic       wr_p = 1'b0;
  logic       fe_p = 1'b0;
  logic       pe_p = 1'b0;

  uart_rx_os #(
    .DIV       (DIV),
    .OS        (OS),
    .DATA_BITS (DB),
    .PARITY_ODD(PODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .dataout   (dataout),
    .wr_EN     (wr_EN),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_EN) begin
      got_d.push_back(dataout);
      got_c.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
    if ((wr_EN && wr_p) || (frame_err && fe_p) || (parity_err && pe_p))
      wide_cnt++;
    wr_p = wr_EN;
    fe_p = frame_err;
    pe_p = parity_err;
  end

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ (PODD != 0);
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (T) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic pbit);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit(pbit);
`else
    if (pbit === 1'bx) rx = 1'b0;
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (dataout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dataout got %h want 00", dataout);
    end
    n_chk++;
    if ({wr_EN, frame_err, parity_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 000",
               {wr_EN, frame_err, parity_err});
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    rst_n = 1'b1;
    idle(2 * T);
  endtask

  task automatic test_basic;
    int base;
    int fe0;
    int st;
    int lat;
    base = got_d.size();
    fe0 = fe_cnt;
    st = cyc;
    send_frame(8'hD3, 1'b1, good_par(8'hD3));
    idle(T);
    last_good = 8'hD3;
    n_chk++;
    if (got_d.size() != base + 1) begin
      n_fail++;
      $display("FAIL basic_count got %0d want %0d", got_d.size(), base + 1);
    end else begin
      n_chk++;
      if (got_d[base] !== 8'b11010011) begin
        n_fail++;
        $display("FAIL basic_data got %h want d3", got_d[base]);
      end
      lat = got_c[base] - st;
      n_chk++;
      if (lat < LAT - DIV || lat > LAT + DIV) begin
        n_fail++;
        $display("FAIL basic_latency got %0d want %0d+-%0d", lat, LAT, DIV);
      end
    end
    n_chk++;
    if (fe_cnt != fe0 || pe_cnt != 0 || wide_cnt != 0) begin
      n_fail++;
      $display("FAIL basic_errs got fe%0d pe%0d wide%0d want 0",
               fe_cnt - fe0, pe_cnt, wide_cnt);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = got_d.size();
    send_frame(8'h00, 1'b1, good_par(8'h00));
    send_frame(8'hFF, 1'b1, good_par(8'hFF));
    idle(T);
    last_good = 8'hFF;
    n_chk++;
    if (got_d.size() != base + 2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want %0d", got_d.size(), base + 2);
    end else begin
      n_chk++;
      if (got_d[base] !== 8'h00 || got_d[base+1] !== 8'hFF) begin
        n_fail++;
        $display("FAIL b2b_data got %h %h want 00 ff",
                 got_d[base], got_d[base+1]);
      end
      n_chk++;
      if (got_c[base+1] - got_c[base] != (10 + P) * T) begin
        n_fail++;
        $display("FAIL b2b_spacing got %0d want %0d",
                 got_c[base+1] - got_c[base], (10 + P) * T);
      end
    end
  endtask

  task automatic test_glitch;
    int base;
    int fe0;
    logic seen;
    base = got_d.size();
    fe0 = fe_cnt;
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 2 * T; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy got seen%b now%b want 1 0", seen, busy);
    end
    n_chk++;
    if (got_d.size() != base || fe_cnt != fe0) begin
      n_fail++;
      $display("FAIL glitch_strobe got wr%0d fe%0d want 0 0",
               got_d.size() - base, fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err;
    int base;
    int fe0;
    int pe0;
    logic brk_busy;
    base = got_d.size();
    fe0 = fe_cnt;
    pe0 = pe_cnt;
    brk_busy = 1'b0;
    send_frame(8'hA5, 1'b0, good_par(8'hA5));
    for (int i = 0; i < 20 * T; i++) begin
      @(negedge clk);
      if (busy) brk_busy = 1'b1;
    end
    idle(2 * T);
    n_chk++;
    if (fe_cnt != fe0 + 1 || pe_cnt != pe0) begin
      n_fail++;
      $display("FAIL ferr_count got fe%0d pe%0d want 1 0",
               fe_cnt - fe0, pe_cnt - pe0);
    end
    n_chk++;
    if (got_d.size() != base) begin
      n_fail++;
      $display("FAIL ferr_wr got %0d want 0", got_d.size() - base);
    end
    n_chk++;
    if (dataout !== last_good) begin
      n_fail++;
      $display("FAIL ferr_hold got %h want %h", dataout, last_good);
    end
    n_chk++;
    if (brk_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL break_busy got %b want 0", brk_busy);
    end
  endtask

  task automatic test_random;
    int base;
    int fe0;
    int nfe;
    logic [7:0] d;
    logic st;
    logic [7:0] exp_q[$];
    base = got_d.size();
    fe0 = fe_cnt;
    nfe = 0;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(d, st, good_par(d));
      if (st) begin
        exp_q.push_back(d);
        last_good = d;
        idle($urandom_range(0, T));
      end else begin
        nfe++;
        idle(T + $urandom_range(0, T));
      end
    end
    idle(T);
    n_chk++;
    if (got_d.size() != base + exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count got %0d want %0d",
               got_d.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_chk++;
        if (got_d[base+i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand_data[%0d] got %h want %h",
                   i, got_d[base+i], exp_q[i]);
        end
      end
    end
    n_chk++;
    if (fe_cnt - fe0 != nfe) begin
      n_fail++;
      $display("FAIL rand_ferr got %0d want %0d", fe_cnt - fe0, nfe);
    end
    n_chk++;
    if (dataout !== last_good) begin
      n_fail++;
      $display("FAIL rand_hold got %h want %h", dataout, last_good);
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    int base;
    int pe0;
    int fe0;
    base = got_d.size();
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(T);
    last_good = 8'h07;
    n_chk++;
    if (got_d.size() != base + 1 || pe_cnt != pe0) begin
      n_fail++;
      $display("FAIL par_good got wr%0d pe%0d want 1 0",
               got_d.size() - base, pe_cnt - pe0);
    end else begin
      n_chk++;
      if (got_d[base] !== 8'h07) begin
        n_fail++;
        $display("FAIL par_data got %h want 07", got_d[base]);
      end
    end
    send_frame(8'h07, 1'b1, 1'b0);
    idle(T);
    n_chk++;
    if (got_d.size() != base + 1 || pe_cnt != pe0 + 1 || fe_cnt != fe0) begin
      n_fail++;
      $display("FAIL par_bad got wr%0d pe%0d fe%0d want 1 1 0",
               got_d.size() - base, pe_cnt - pe0, fe_cnt - fe0);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int base;
    logic [7:0] d;
    d = 8'h3C;
    base = got_d.size();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (T / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (dataout !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_out got %h %b want 00 0", dataout, busy);
    end
    n_chk++;
    if ({wr_EN, frame_err, parity_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_strobes got %b want 000",
               {wr_EN, frame_err, parity_err});
    end
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3 * T);
    n_chk++;
    if (got_d.size() != base) begin
      n_fail++;
      $display("FAIL rstmid_abort got %0d want 0", got_d.size() - base);
    end
    send_frame(d, 1'b1, good_par(d));
    idle(T);
    n_chk++;
    if (got_d.size() != base + 1) begin
      n_fail++;
      $display("FAIL rstmid_count got %0d want 1", got_d.size() - base);
    end else begin
      n_chk++;
      if (got_d[base] !== 8'h3C) begin
        n_fail++;
        $display("FAIL rstmid_data got %h want 3c", got_d[base]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_random;
`ifdef UART_PARITY_EN
    test_parity;
`endif
    test_reset_mid;
    n_chk++;
    if (wide_cnt != 0) begin
      n_fail++;
      $display("FAIL strobe_width got %0d wide strobes want 0", wide_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver running from the single system clock, the receive end paired with the team's `transmitter`. It synchronises the serial `rx` line, derives a 16x oversample tick internally, validates the start bit at its centre, and majority-votes each data bit. Completed bytes are presented on `dataout` with a one-cycle `wr_EN` strobe, ready to push into the downstream RX FIFO.

## Interface
Parameters:
- `DIV`, 4 — clk cycles per oversample tick (≥1)
- `OS`, 16 — oversample ticks per bit (even, ≥8)
- `DATA_BITS`, 8 — payload bits per frame
- `PARITY_ODD`, 0 — 0 even, 1 odd; used only with `UART_PARITY_EN`

Ports (`clk`: one clock; `rst_n`: asynchronous, active-low reset):
- `clk` in 1 — system clock
- `rst_n` in 1 — asynchronous active-low reset
- `rx` in 1 — serial line, idle high, LSB first
- `dataout` out DATA_BITS — last good byte, held until next good byte
- `wr_EN` out 1 — one-cycle strobe, `dataout` valid in same cycle
- `frame_err` out 1 — one-cycle strobe, stop bit sampled 0
- `parity_err` out 1 — one-cycle strobe, parity mismatch (tied 0 without macro)
- `busy` out 1 — high in every state except IDLE

## Operation
- `rx` passes through 2-FF synchroniser (reset to 1), then a 3-bit history shifted on every tick; sampled value = majority of history.
- Tick divider: `div_cnt` 0..DIV-1, tick when `div_cnt==DIV-1`; cleared on start-edge detection.
- `os_cnt` counts ticks within a bit, 0..OS-1, wraps to 0.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: synced `rx` 1→0 → START, clear `div_cnt`, `os_cnt`, history set to 3'b000.
- START: at tick with `os_cnt==OS/2-1`: majority 0 → DATA, `os_cnt`←0, `bit_cnt`←0; majority 1 → IDLE (glitch rejected, no strobe).
- DATA: at tick with `os_cnt==OS-1` (bit centre): shift majority into MSB of shift register (right shift, LSB first); after DATA_BITS samples → PARITY or STOP.
- PARITY: at centre, compare majority with XOR of data (XNOR if `PARITY_ODD`).
- STOP: at centre: majority 1 and no parity error → `dataout`←shift reg, `wr_EN` pulse; majority 0 → `frame_err` pulse, `dataout` unchanged; parity error (stop good) → `parity_err` pulse, no `wr_EN`. Both errors → both error strobes, no `wr_EN`. Always → IDLE.
- Break / line held low after STOP: no new start until synced `rx` returns high then falls.

## Timing
- Reset values: `dataout`=0, `wr_EN`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state IDLE, all counters 0.
- `rst_n` low mid-frame: immediate abort, no strobes, outputs to reset values.
- Bit period T = OS·DIV clk. Strobes assert on the clk edge after the stop-centre tick, high exactly 1 cycle.
- Latency start edge at pin → `wr_EN`: (1 + DATA_BITS + P + 0.5)·T ± 1 tick + 3 clk (P=1 with parity).
- `busy` rises 3 clk after start edge at pin, falls with the strobe cycle.
- Tolerates ±3% baud mismatch at OS=16.

## Configuration
- `UART_PARITY_EN` defined: PARITY state included, one parity bit expected between data and stop, `parity_err` driven.
- Undefined: frame = start + DATA_BITS + stop, PARITY state absent, `parity_err` constant 0, `PARITY_ODD` ignored.

## Structure
- `uart_pkg`: `rx_state_t` enum, default `OS`/`DATA_BITS` constants, shared with `transmitter`.
- Sub-module `uart_baud_tick`: divider with sync clear, outputs `tick`.
- Majority vote and synchroniser inline in `uart_rx_os`.

## Test plan
- Reset released, frame 8'hD3 at T=64 clk → `wr_EN` one cycle, `dataout`=8'b11010011, no error strobes.
- Back-to-back 8'h00 then 8'hFF, no idle gap → two `wr_EN` strobes, values 00 then FF, 10·T apart.
- 1-tick low glitch (DIV clk) on idle `rx` → stays IDLE, `busy` drops, no strobe.
- Frame 8'hA5 with stop bit forced 0 → `frame_err` pulse, no `wr_EN`, `dataout` retains previous value.
- `UART_PARITY_EN`, even: 8'h07 with parity 1 → `wr_EN`, `dataout`=07; parity 0 → `parity_err`, no `wr_EN`.
- `rst_n` pulsed low at bit 4 of 8'h3C → all outputs 0, next clean frame 8'h3C received correctly.
